// File: rtl/fx_pt_sub_pipe_pkg.sv
// Shared fixed-point datapath types for the fx_pt add/sub pipeline family.
package fx_pt_pkg;

    localparam int FX_WORD_LEN = 32;

    typedef logic [FX_WORD_LEN-1:0] fx_word_t;

    // Stage-1 record: widened difference plus its borrow-out
    typedef struct packed {
        logic [FX_WORD_LEN:0] diff;
        logic                 borrow;
    } fx_s1_t;

endpackage

// File: rtl/fx_pt_sub_pipe_if.sv
// Streaming operand/result bus of the saturating subtractor, with statistics.
interface fx_pt_sub_pipe_if #(
    parameter int WORD_LEN = 32,
    parameter int CNT_LEN  = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [WORD_LEN-1:0] in1;
    logic [WORD_LEN-1:0] in2;
    logic                out_valid;
    logic                out_ready;
    logic [WORD_LEN-1:0] out;
    logic                out_sat;
    logic                sat_sticky;
    logic [CNT_LEN-1:0]  sat_count;
    logic                stat_clr;

    modport master (
        output in_valid, in1, in2, out_ready, stat_clr,
        input  in_ready, out_valid, out, out_sat, sat_sticky, sat_count
    );

    modport slave (
        input  in_valid, in1, in2, out_ready, stat_clr,
        output in_ready, out_valid, out, out_sat, sat_sticky, sat_count
    );
endinterface

// File: rtl/fx_pt_sub_pipe_sat_counter.sv
// Saturating event counter with sticky flag; clear wins over a same-cycle increment.
module fx_sat_counter #(
    parameter int CNT_LEN = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [CNT_LEN-1:0] count_o,
    output logic               sticky_o
);
    logic [CNT_LEN-1:0] count_q;
    logic               sticky_q;

    // Counter and sticky flag update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= {CNT_LEN{1'b0}};
            sticky_q <= 1'b0;
        end else if (clr_i) begin
            count_q  <= {CNT_LEN{1'b0}};
            sticky_q <= 1'b0;
        end else if (inc_i) begin
            sticky_q <= 1'b1;
            if (count_q != {CNT_LEN{1'b1}}) begin
                count_q <= count_q + CNT_LEN'(1);
            end
        end
    end

    assign count_o  = count_q;
    assign sticky_o = sticky_q;
endmodule

// File: rtl/fx_pt_sub_pipe.sv
// Two-stage saturating unsigned subtractor: S1 registers diff/borrow, S2 clamps.
module fx_pt_sub_pipe
    import fx_pt_pkg::*;
#(
    parameter int WORD_LEN = FX_WORD_LEN,
    parameter int CNT_LEN  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    fx_pt_sub_pipe_if.slave bus
);
    logic                s2_adv_s;
    logic                s1_adv_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                out_xfer_s;
    logic [WORD_LEN:0]   diff_s;

    fx_s1_t              s1_d, s1_q;
    logic                s1_valid_d, s1_valid_q;
    logic                s2_valid_d, s2_valid_q;
    logic [WORD_LEN-1:0] out_d, out_q;
    logic                out_sat_d, out_sat_q;

    // Handshake decisions; in_ready follows out_ready combinationally (no skid buffer)
    always_comb begin
        s2_adv_s   = !s2_valid_q || bus.out_ready;
        s1_adv_s   = s1_valid_q && s2_adv_s;
        in_ready_s = !s1_valid_q || s2_adv_s;
        accept_s   = bus.in_valid && in_ready_s;
        out_xfer_s = s2_valid_q && bus.out_ready;
        diff_s     = {1'b0, bus.in1} - {1'b0, bus.in2};
    end

    // Stage-1 next state
    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        if (accept_s) begin
            s1_valid_d  = 1'b1;
            s1_d.diff   = (FX_WORD_LEN + 1)'(diff_s);
            s1_d.borrow = diff_s[WORD_LEN];
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage-2 next state: clamp to zero on borrow
    always_comb begin
        s2_valid_d = s2_valid_q;
        out_d      = out_q;
        out_sat_d  = out_sat_q;
        if (s1_adv_s) begin
            s2_valid_d = 1'b1;
            out_d      = s1_q.borrow ? {WORD_LEN{1'b0}} : s1_q.diff[WORD_LEN-1:0];
            out_sat_d  = s1_q.borrow;
        end else if (out_xfer_s) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Valid bits and visible result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            out_q      <= {WORD_LEN{1'b0}};
            out_sat_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            out_q      <= out_d;
            out_sat_q  <= out_sat_d;
        end
    end

    // Stage-1 payload needs no reset; it is only observed behind s1_valid
    always_ff @(posedge clk) begin
        s1_q <= s1_d;
    end

    fx_sat_counter #(.CNT_LEN(CNT_LEN)) u_sat_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (bus.stat_clr),
        .inc_i    (out_xfer_s && out_sat_q),
        .count_o  (bus.sat_count),
        .sticky_o (bus.sat_sticky)
    );

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = s2_valid_q;
    assign bus.out       = out_q;
    assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_fx_pt_sub_pipe.sv
// Self-checking bench: directed vectors, stall/reset sequences, random traffic vs. a queue model.
module tb_fx_pt_sub_pipe;
    localparam int WL      = 32;
    localparam int CL      = 4;
    localparam int CNT_MAX = 15;

    typedef struct { logic [31:0] res; logic sat; } res_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] exp_out; logic exp_sat; } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fx_pt_sub_pipe_if #(.WORD_LEN(WL), .CNT_LEN(CL)) bus ();
    fx_pt_sub_pipe #(.WORD_LEN(WL), .CNT_LEN(CL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int          n_tests = 0;
    int          n_fail  = 0;
    res_t        exp_q[$];
    int          m_cnt;
    logic        m_sticky;
    bit          chk_en;
    bit          prev_stall;
    logic [31:0] prev_out;
    logic        prev_sat;
    vec_t        vecs[9];

    function automatic void chk(string name, longint unsigned act, longint unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    // Reference: clamped difference, flagged when the subtrahend is larger
    function automatic res_t ref_sub(logic [31:0] a, logic [31:0] b);
        res_t r;
        if (b > a) begin r.res = 32'd0; r.sat = 1'b1; end
        else       begin r.res = a - b; r.sat = 1'b0; end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard, statistics model and stall-stability checks
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("sat_count", bus.sat_count, m_cnt);
                chk("sat_sticky", bus.sat_sticky, m_sticky);
                if (prev_stall) begin
                    chk("hold_valid", bus.out_valid, 1);
                    chk("hold_out", bus.out, prev_out);
                    chk("hold_sat", bus.out_sat, prev_sat);
                end
                if (!rst_n) begin
                    exp_q.delete();
                    m_cnt = 0; m_sticky = 1'b0; prev_stall = 1'b0;
                end else begin
                    e.sat = 1'b0;
                    if (bus.out_valid && bus.out_ready) begin
                        chk("out_pending", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk("out", bus.out, e.res);
                            chk("out_sat", bus.out_sat, e.sat);
                        end
                    end
                    if (bus.stat_clr) begin
                        m_cnt = 0; m_sticky = 1'b0;
                    end else if (bus.out_valid && bus.out_ready && e.sat) begin
                        m_sticky = 1'b1;
                        if (m_cnt < CNT_MAX) m_cnt++;
                    end
                    if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_sub(bus.in1, bus.in2));
                    prev_stall = bus.out_valid && !bus.out_ready;
                    prev_out   = bus.out;
                    prev_sat   = bus.out_sat;
                end
            end
        end
    end

    initial begin
        int acc;
        int exp_cnt;
        logic [31:0] a;
        vecs[0] = '{32'd100,       32'd30,        32'd70,        1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1'b0};
        vecs[2] = '{32'd5,         32'd6,         32'd0,         1'b1};
        vecs[3] = '{32'd0,         32'hFFFF_FFFF, 32'd0,         1'b1};
        vecs[4] = '{32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 1'b0};
        vecs[5] = '{32'd0,         32'd0,         32'd0,         1'b0};
        vecs[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd1,         1'b0};
        vecs[7] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd0,         1'b1};
        vecs[8] = '{32'h1234_5678, 32'd1,         32'h1234_5677, 1'b0};

        m_cnt = 0; m_sticky = 1'b0; chk_en = 1'b0; prev_stall = 1'b0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in1 = 32'd0; bus.in2 = 32'd0;
        bus.out_ready = 1'b0; bus.stat_clr = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out", bus.out, 0);
        chk("rst_out_sat", bus.out_sat, 0);
        chk("rst_sticky", bus.sat_sticky, 0);
        chk("rst_count", bus.sat_count, 0);
        tick();
        rst_n = 1'b1; chk_en = 1'b1;
        tick();

        // Directed vectors: two-edge latency, clamp and statistics
        exp_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            bus.in1 = vecs[i].a; bus.in2 = vecs[i].b;
            bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            @(negedge clk);
            chk("vec_latency_early", bus.out_valid, 0);
            tick();
            @(negedge clk);
            chk("vec_valid", bus.out_valid, 1);
            chk("vec_out", bus.out, vecs[i].exp_out);
            chk("vec_sat", bus.out_sat, vecs[i].exp_sat);
            tick();
            if (vecs[i].exp_sat) exp_cnt++;
            @(negedge clk);
            chk("vec_count", bus.sat_count, exp_cnt);
            chk("vec_sticky", bus.sat_sticky, exp_cnt != 0);
            tick();
        end

        // Back-pressure: only two pairs fit, then drain in order
        bus.out_ready = 1'b0; acc = 0;
        for (int k = 0; k < 4; k++) begin
            bus.in1 = 32'd1000 + 32'(k); bus.in2 = (k == 1) ? 32'd5000 : 32'd7;
            bus.in_valid = 1'b1;
            @(negedge clk);
            if (bus.in_ready) acc++;
            tick();
        end
        @(negedge clk);
        chk("bp_accepted", acc, 2);
        chk("bp_in_ready", bus.in_ready, 0);
        tick();
        bus.in_valid = 1'b0;
        tick(); tick(); tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_first", bus.out_valid, 1);
        tick();
        @(negedge clk);
        chk("bp_second", bus.out_valid, 1);
        tick();
        @(negedge clk);
        chk("bp_empty", bus.out_valid, 0);
        tick();

        // Full throughput with random pairs
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            bus.in1 = a;
            case ($urandom_range(0, 3))
                0:       bus.in2 = a;
                1:       bus.in2 = a + 32'($urandom_range(1, 50));
                default: bus.in2 = $urandom;
            endcase
            bus.in_valid = 1'b1;
            @(negedge clk);
            chk("tp_in_ready", bus.in_ready, 1);
            if (i >= 2) chk("tp_no_bubble", bus.out_valid, 1);
            tick();
        end
        bus.in_valid = 1'b0;
        tick(); tick(); tick();

        // Counter saturation at 15
        bus.stat_clr = 1'b1;
        tick();
        bus.stat_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a = 32'($urandom_range(0, 100));
            bus.in1 = a; bus.in2 = a + 32'd1; bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        chk("cnt_saturated", bus.sat_count, 15);
        chk("cnt_sticky", bus.sat_sticky, 1);
        tick();

        // Clear in the same cycle as an underflow transfer
        bus.out_ready = 1'b0;
        bus.in1 = 32'd3; bus.in2 = 32'd9; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("clr_pending_sat", bus.out_sat, 1);
        tick();
        bus.out_ready = 1'b1; bus.stat_clr = 1'b1;
        tick();
        bus.stat_clr = 1'b0;
        @(negedge clk);
        chk("clr_count", bus.sat_count, 0);
        chk("clr_sticky", bus.sat_sticky, 0);
        tick();

        // Reset with both stages full
        bus.in1 = 32'd1; bus.in2 = 32'd2; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rs_count_before", bus.sat_count, 1);
        tick();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in1 = 32'd50; bus.in2 = 32'd60;
        tick(); tick();
        @(negedge clk);
        chk("rs_full", bus.in_ready, 0);
        tick();
        rst_n = 1'b0; bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rs_out_valid", bus.out_valid, 0);
        chk("rs_in_ready", bus.in_ready, 1);
        chk("rs_count", bus.sat_count, 0);
        chk("rs_sticky", bus.sat_sticky, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("rs_no_stale", bus.out_valid, 0);
        end
        tick();

        // Random handshakes and clears
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 1) == 1);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.stat_clr  = ($urandom_range(0, 19) == 0);
            a = $urandom;
            bus.in1 = a;
            bus.in2 = ($urandom_range(0, 1) == 1) ? a - 32'($urandom_range(0, 9)) : $urandom;
            tick();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.stat_clr = 1'b0;
        tick(); tick(); tick(); tick();
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fx_pt_sub_pipe.md
# fx_pt_sub_pipe

Pipelined, saturating unsigned fixed-point subtractor, the inverse-direction companion to the saturating fixed-point adder. It computes `in1 - in2` on `WORD_LEN`-bit unsigned operands and clamps any underflow (borrow) to zero. It sits in the streaming arithmetic datapath behind a valid/ready handshake, and keeps a sticky underflow flag plus a saturating underflow event counter for monitoring.

## Interface
- `WORD_LEN`, default 32: operand and result width.
- `CNT_LEN`, default 16: width of the underflow event counter.
- `clk`  in  1: clock; all logic is on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `in_valid`  in  1: operand pair is valid.
- `in_ready`  out  1: block accepts the pair this cycle.
- `in1`  in  WORD_LEN: minuend, unsigned.
- `in2`  in  WORD_LEN: subtrahend, unsigned.
- `out_valid`  out  1: result is valid.
- `out_ready`  in  1: downstream accepts the result.
- `out`  out  WORD_LEN: clamped difference.
- `out_sat`  out  1: this result was clamped (underflow).
- `sat_sticky`  out  1: an underflow has occurred since reset or clear.
- `sat_count`  out  CNT_LEN: number of underflow results delivered, saturating.
- `stat_clr`  in  1: synchronous clear of `sat_sticky` and `sat_count`.

## Operation
- Transfers occur on `in_valid && in_ready` and on `out_valid && out_ready`.
- **Stage 1 (S1)** on accept:
  - registers `diff = {1'b0,in1} - {1'b0,in2}`, which is `WORD_LEN+1` bits wide.
  - registers `borrow = diff[WORD_LEN]`.
  - sets `s1_valid`.
- **Stage 2 (S2)** on advance:
  - registers `out = borrow ? '0 : diff[WORD_LEN-1:0]`.
  - registers `out_sat = borrow`.
  - sets `s2_valid`.
- `out_valid = s2_valid`.
- Equal operands give 0 with `out_sat=0`. Only a true borrow saturates.
- **Flow control:**
  - `s2_adv = !s2_valid || out_ready`
  - `s1_adv = s1_valid && s2_adv`
  - `in_ready = !s1_valid || s2_adv`
  - `in_ready` depends combinationally on `out_ready`. There is no skid buffer.
- **Register updates:**
  - S1 loads on accept. S1 clears `s1_valid` when it advances with no new accept.
  - S2 loads when `s1_adv`. S2 clears `s2_valid` on output transfer with no `s1_adv`.
- **Statistics:** each output transfer with `out_sat=1` sets `sat_sticky` and increments `sat_count`. `sat_count` holds at all-ones.
- `stat_clr` has priority over a same-cycle increment: the result is count 0 and sticky 0.
- Data registers do not need reset. Only the valid bits and statistics reset.

## Timing
- Reset values:
  - `in_ready=1`
  - `out_valid=0`
  - `out_sat=0`
  - `out=0`; reset `out` to keep the bench X-free.
  - `sat_sticky=0`
  - `sat_count=0`
- Latency: an operand pair accepted at edge N gives `out_valid=1` after edge N+1 when the pipeline is empty.
- Throughput: one result per cycle while `out_ready=1`.
- Stall: with `out_ready=0`, at most 2 pairs are held.
  - `in_ready` falls when S1 and S2 are both full.
  - `out`, `out_sat` and `out_valid` hold stable until the output transfer.
- Simultaneous accept and S1 advance in one cycle: S1 takes the new pair, and S2 takes the old one.
- Reset mid-operation: valids clear on the next edge and in-flight data is discarded. Statistics clear.
- Statistics update on the same edge as the output transfer. The new values are visible the following cycle.

## Structure
- Shared package `fx_pt_pkg`:
  - `WORD_LEN` default constant (32).
  - `fx_word_t` typedef.
  - Stage-1 struct typedef `{diff, borrow}`, reused by `fx_pt_add`-family pipelines.
- Natural sub-module: `fx_sat_counter`, a saturating up-counter with clear priority and a sticky flag.
- The two pipeline stages stay inline.

## Test plan
- **Basic:** `in1=100`, `in2=30`, `out_ready=1`.
  - Expect `out=70`, `out_sat=0` two edges after accept.
  - `in1=in2=0xFFFF_FFFF` gives `out=0`, `out_sat=0`.
- **Underflow:** `in1=5`, `in2=6`.
  - Expect `out=0`, `out_sat=1`, then `sat_sticky=1`, `sat_count=1`.
  - `in1=0`, `in2=0xFFFF_FFFF` also clamps.
- **Back-pressure:** stream 4 pairs with `out_ready=0`.
  - Exactly 2 are accepted and `in_ready=0`.
  - Raise `out_ready`: results appear in order, one per cycle, and outputs held stable while stalled.
- **Full throughput:** 1000 random pairs with `in_valid=1`, `out_ready=1`.
  - Every result matches the reference model: `max(in1-in2,0)`.
  - No bubbles after the first result.
- **Counter:** with `CNT_LEN=4`, send 20 underflows. `sat_count` stops at 15.
  - Assert `stat_clr` in the same cycle as an underflow transfer: count becomes 0 and sticky becomes 0.
- **Reset mid-stream:** drop `rst_n` for 1 cycle with both stages full.
  - Next cycle `out_valid=0` and `in_ready=1`, statistics are 0, and no stale result appears.
